// File: rtl/or1200_icpu_resp_if.sv
// Fetch-port and instruction-memory signals of or1200_icpu_resp.
// The _i/_o suffixes are named from the responder's side of the link.
interface or1200_icpu_resp_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          icpu_cycstb_i;
  logic [AW-1:0] icpu_adr_i;
  logic [3:0]    icpu_sel_i;
  logic [3:0]    icpu_tag_i;
  logic [2:0]    icpu_thread_i;
  logic          icpu_flush_i;
  logic          icpu_ack_o;
  logic          icpu_err_o;
  logic          icpu_rty_o;
  logic [DW-1:0] icpu_dat_o;
  logic [AW-1:0] icpu_adr_o;
  logic [3:0]    icpu_tag_o;
  logic [2:0]    icpu_thread_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_adr_o;
  logic [3:0]    mem_sel_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_err_i;

  modport slave (
    input  icpu_cycstb_i, icpu_adr_i, icpu_sel_i, icpu_tag_i, icpu_thread_i, icpu_flush_i,
    output icpu_ack_o, icpu_err_o, icpu_rty_o, icpu_dat_o, icpu_adr_o, icpu_tag_o, icpu_thread_o,
    output mem_req_o, mem_adr_o, mem_sel_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport master (
    output icpu_cycstb_i, icpu_adr_i, icpu_sel_i, icpu_tag_i, icpu_thread_i, icpu_flush_i,
    input  icpu_ack_o, icpu_err_o, icpu_rty_o, icpu_dat_o, icpu_adr_o, icpu_tag_o, icpu_thread_o,
    input  mem_req_o, mem_adr_o, mem_sel_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/or1200_icpu_resp.sv
// Instruction-side fetch responder: one memory read per genpc request, ack/err with echoed tag/thread.
// Optional one-entry last-word buffer enabled by defining OR1200_ICPU_RESP_LASTHIT_EN.
module or1200_icpu_resp #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  or1200_icpu_resp_if.slave bus
);
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e        state_q;
  logic [AW-1:0] adr_q;
  logic [3:0]    sel_q;
  logic [3:0]    tag_q;
  logic [2:0]    thread_q;
  logic [DW-1:0] dat_q;
  logic          err_q;
  logic          drop_q;
  logic [CW-1:0] cnt_q;

  logic          abandon;
  logic          resp_vis;
  logic          hit;
  logic [DW-1:0] hit_dat;

  // genpc moving to another address (or flushing) means nobody wants the in-flight word.
  assign abandon = bus.icpu_flush_i ||
                   (bus.icpu_cycstb_i && (bus.icpu_adr_i[AW-1:2] != adr_q[AW-1:2]));

`ifdef OR1200_ICPU_RESP_LASTHIT_EN
  logic [AW-1:2] lh_adr_q;
  logic [DW-1:0] lh_dat_q;
  logic          lh_vld_q;

  assign hit     = lh_vld_q && (bus.icpu_adr_i[AW-1:2] == lh_adr_q);
  assign hit_dat = lh_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lh_vld_q <= 1'b0;
      lh_adr_q <= '0;
      lh_dat_q <= '0;
    end else if (bus.icpu_flush_i) begin
      lh_vld_q <= 1'b0;
    end else if (state_q == RESP && !drop_q && !err_q) begin
      lh_vld_q <= 1'b1;
      lh_adr_q <= adr_q[AW-1:2];
      lh_dat_q <= dat_q;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_dat = '0;
`endif

  // NOTE: every state register uses <= so all next-state terms read the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      sel_q    <= '0;
      tag_q    <= '0;
      thread_q <= '0;
      dat_q    <= '0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.icpu_cycstb_i && !bus.icpu_flush_i) begin
            adr_q    <= bus.icpu_adr_i;
            sel_q    <= bus.icpu_sel_i;
            tag_q    <= bus.icpu_tag_i;
            thread_q <= bus.icpu_thread_i;
            drop_q   <= 1'b0;
            if (hit) begin
              dat_q   <= hit_dat;
              err_q   <= 1'b0;
              state_q <= RESP;
            end else begin
              state_q <= ADDR;
            end
          end
        end
        ADDR: begin
          if (abandon) drop_q <= 1'b1;
          if (bus.mem_gnt_i) begin
            cnt_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (abandon) drop_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_rvalid_i) begin
            dat_q   <= bus.mem_rdata_i;
            err_q   <= bus.mem_err_i;
            state_q <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          drop_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the pulse is decoded from registered state but gated by the live flush so a
  // refetch arriving in the response cycle still cancels delivery.
  assign resp_vis          = (state_q == RESP) && !drop_q && !bus.icpu_flush_i;
  assign bus.icpu_ack_o    = resp_vis && !err_q;
  assign bus.icpu_err_o    = resp_vis && err_q;
  assign bus.icpu_rty_o    = bus.icpu_cycstb_i && (state_q != IDLE) && !resp_vis;
  assign bus.icpu_dat_o    = dat_q;
  assign bus.icpu_adr_o    = adr_q;
  assign bus.icpu_tag_o    = tag_q;
  assign bus.icpu_thread_o = thread_q;
  assign bus.mem_req_o     = (state_q == ADDR);
  assign bus.mem_adr_o     = {adr_q[AW-1:2], 2'b00};
  assign bus.mem_sel_o     = sel_q;
endmodule

// File: tb/tb_or1200_icpu_resp.sv
// Self-checking bench for or1200_icpu_resp: vector table, scoreboard of expected responses,
// reactive memory model, and hand-written abandon / reset / last-hit sequences.
module tb_or1200_icpu_resp;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  or1200_icpu_resp_if #(.AW(AW), .DW(DW)) bus ();

  or1200_icpu_resp #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [3:0]  tag;
    logic [2:0]  thread;
    int          gnt_wait;
    int          rv_wait;
    bit          rv_en;
    bit          merr;
    logic [31:0] rdata;
    bit          exp_err;
    int          exp_lat;   // cycles from accept cycle to response cycle
    int          exp_req;   // cycles mem_req_o is high
  } vec_t;

  typedef struct {
    int          at_cyc;
    bit          is_err;
    logic [31:0] dat;
    logic [31:0] adr;
    logic [3:0]  tag;
    logic [2:0]  thread;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_resp   = 0;
  int  cyc      = 0;

  int          cfg_gnt_wait = 0;
  int          cfg_rv_wait  = 0;
  bit          cfg_rv_en    = 1'b1;
  bit          cfg_err      = 1'b0;
  logic [31:0] cfg_rdata    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: grants after cfg_gnt_wait request cycles, returns data cfg_rv_wait cycles after grant.
  initial begin : mem_model
    int          gnt_cnt;
    int          rv_cnt;
    bit          rv_pend;
    logic [31:0] rd;
    gnt_cnt = 0; rv_cnt = 0; rv_pend = 1'b0; rd = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.mem_err_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_err_i = 1'b0; bus.mem_rdata_i = '0;
      if (rv_pend) begin
        if (rv_cnt == cfg_rv_wait) begin
          rv_pend = 1'b0;
          if (cfg_rv_en) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rd;
            bus.mem_err_i    = cfg_err;
          end
        end else begin
          rv_cnt++;
        end
      end else if (bus.mem_req_o) begin
        if (gnt_cnt == cfg_gnt_wait) begin
          bus.mem_gnt_i = 1'b1;
          gnt_cnt = 0; rv_pend = 1'b1; rv_cnt = 0; rd = cfg_rdata;
        end else begin
          gnt_cnt++;
        end
      end else begin
        gnt_cnt = 0;
      end
    end
  end

  // Response monitor: every ack/err pulse must match the oldest expected response.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (bus.icpu_ack_o || bus.icpu_err_o) begin
      n_resp++;
      check("resp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_cycle", cyc, e.at_cyc);
        check("resp_ack", bus.icpu_ack_o, !e.is_err);
        check("resp_err", bus.icpu_err_o, e.is_err);
        if (!e.is_err) check("resp_dat", bus.icpu_dat_o, e.dat);
        check("resp_adr", bus.icpu_adr_o, e.adr);
        check("resp_tag", bus.icpu_tag_o, e.tag);
        check("resp_thread", bus.icpu_thread_o, e.thread);
      end
    end
  end

  // Called in the accept cycle (just after its rising edge); holds cycstb until ack/err.
  task automatic wait_resp(input string name, input int exp_rty, input int exp_req,
                           input logic [31:0] adr, input logic [3:0] sel);
    int          rty_n = 0;
    int          req_n = 0;
    bit          got   = 1'b0;
    logic [31:0] madr  = '0;
    logic [3:0]  msel  = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.icpu_rty_o) rty_n++;
      if (bus.mem_req_o) begin
        req_n++;
        madr = bus.mem_adr_o;
        msel = bus.mem_sel_o;
      end
      if (bus.icpu_ack_o || bus.icpu_err_o) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_done"}, got, 1);
    check({name, "_rty_cycles"}, rty_n, exp_rty);
    check({name, "_req_cycles"}, req_n, exp_req);
    if (exp_req > 0) begin
      check({name, "_mem_adr"}, madr, {adr[31:2], 2'b00});
      check({name, "_mem_sel"}, msel, sel);
    end
    @(posedge clk); #1;
    bus.icpu_cycstb_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    sb_t e;
    cfg_gnt_wait = v.gnt_wait; cfg_rv_wait = v.rv_wait; cfg_rv_en = v.rv_en;
    cfg_err = v.merr; cfg_rdata = v.rdata;
    @(posedge clk); #1;
    bus.icpu_cycstb_i = 1'b1;
    bus.icpu_adr_i    = v.adr;
    bus.icpu_sel_i    = v.sel;
    bus.icpu_tag_i    = v.tag;
    bus.icpu_thread_i = v.thread;
    e = '{at_cyc: cyc + v.exp_lat, is_err: v.exp_err, dat: v.rdata,
          adr: v.adr, tag: v.tag, thread: v.thread};
    sb.push_back(e);
    wait_resp(name, v.exp_lat - 1, v.exp_req, v.adr, v.sel);
  endtask

  // mode 0: address changes in DATA; 1: flush in ADDR; 2: flush in RESP. The first fetch is
  // silently dropped, then the held request (at a1) is accepted right after and acked normally.
  task automatic abandon_seq(input logic [31:0] a0, input logic [31:0] a1, input int mode,
                             input logic [31:0] d1, input string name);
    sb_t e;
    cfg_gnt_wait = 0; cfg_rv_wait = 0; cfg_rv_en = 1'b1; cfg_err = 1'b0;
    cfg_rdata = 32'h1500_0000;
    @(posedge clk); #1;
    bus.icpu_cycstb_i = 1'b1; bus.icpu_adr_i = a0; bus.icpu_sel_i = 4'hF;
    bus.icpu_tag_i = 4'h1; bus.icpu_thread_i = 3'd1;
    @(posedge clk); #1;
    if (mode == 1) bus.icpu_flush_i = 1'b1;
    @(posedge clk); #1;
    bus.icpu_flush_i = 1'b0;
    if (mode == 0) bus.icpu_adr_i = a1;
    @(posedge clk); #1;
    if (mode == 2) bus.icpu_flush_i = 1'b1;
    cfg_rdata = d1;
    @(negedge clk);
    check({name, "_no_ack"}, bus.icpu_ack_o, 0);
    check({name, "_no_err"}, bus.icpu_err_o, 0);
    check({name, "_rty_in_resp"}, bus.icpu_rty_o, 1);
    @(posedge clk); #1;
    bus.icpu_flush_i = 1'b0;
    e = '{at_cyc: cyc + 3, is_err: 1'b0, dat: d1, adr: a1, tag: 4'h1, thread: 3'd1};
    sb.push_back(e);
    wait_resp({name, "_refetch"}, 2, 1, a1, 4'hF);
  endtask

  task automatic reset_mid_data();
    int n0;
    cfg_gnt_wait = 0; cfg_rv_wait = 5; cfg_rv_en = 1'b1; cfg_err = 1'b0;
    cfg_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.icpu_cycstb_i = 1'b1; bus.icpu_adr_i = 32'h800; bus.icpu_sel_i = 4'hF;
    bus.icpu_tag_i = 4'h2; bus.icpu_thread_i = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_tag", bus.icpu_tag_o, 4'h2);
    rst_n = 1'b0;
    #1;
    check("rst_async_ack", bus.icpu_ack_o, 0);
    check("rst_async_err", bus.icpu_err_o, 0);
    check("rst_async_rty", bus.icpu_rty_o, 0);
    check("rst_async_req", bus.mem_req_o, 0);
    check("rst_async_adr", bus.icpu_adr_o, 0);
    check("rst_async_tag", bus.icpu_tag_o, 0);
    check("rst_async_thread", bus.icpu_thread_o, 0);
    bus.icpu_cycstb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_resp;
    repeat (10) @(posedge clk);
    #1;
    check("rst_late_rvalid_no_resp", n_resp, n0);
    check("rst_idle_no_req", bus.mem_req_o, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[7];
    vec_t lv;
    //           adr           sel   tag   thr   gw rw en er rdata          err lat req
    vecs[0] = '{32'h0000_0100, 4'hF, 4'h3, 3'd5, 0, 0, 1, 0, 32'h1500_0000, 0, 3,  1};
    vecs[1] = '{32'h0000_0104, 4'h3, 4'hA, 3'd2, 4, 0, 1, 0, 32'h9C21_0004, 0, 7,  5};
    vecs[2] = '{32'h0000_0208, 4'hC, 4'hF, 3'd7, 1, 2, 1, 0, 32'hDEAD_BEEF, 0, 6,  2};
    vecs[3] = '{32'h0000_030C, 4'hF, 4'h0, 3'd0, 0, 1, 1, 1, 32'h0BAD_F00D, 1, 4,  1};
    vecs[4] = '{32'h0000_0400, 4'hF, 4'h6, 3'd1, 0, 0, 0, 0, 32'h0000_0000, 1, 18, 1};
    vecs[5] = '{32'h0000_0500, 4'hF, 4'h7, 3'd3, 0, 15, 1, 0, 32'h1234_5678, 0, 18, 1};
    vecs[6] = '{32'h0000_0600, 4'hF, 4'h8, 3'd4, 2, 16, 1, 0, 32'hCAFE_F00D, 1, 20, 3};

    bus.icpu_cycstb_i = 1'b1; bus.icpu_adr_i = 32'h0000_0ABC; bus.icpu_sel_i = 4'hF;
    bus.icpu_tag_i = 4'h5; bus.icpu_thread_i = 3'd1; bus.icpu_flush_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", bus.icpu_ack_o, 0);
    check("reset_err", bus.icpu_err_o, 0);
    check("reset_rty", bus.icpu_rty_o, 0);
    check("reset_mem_req", bus.mem_req_o, 0);
    check("reset_dat", bus.icpu_dat_o, 0);
    check("reset_adr", bus.icpu_adr_o, 0);
    check("reset_tag", bus.icpu_tag_o, 0);
    check("reset_thread", bus.icpu_thread_o, 0);
    check("reset_mem_adr", bus.mem_adr_o, 0);
    check("reset_mem_sel", bus.mem_sel_o, 0);
    bus.icpu_cycstb_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    reset_mid_data();
    abandon_seq(32'h0000_0100, 32'hF0F0_F0F0, 0, 32'hA5A5_0001, "abandon_adr");
    abandon_seq(32'h0000_0700, 32'h0000_0700, 1, 32'hA5A5_0002, "abandon_flush_addr");
    abandon_seq(32'h0000_0710, 32'h0000_0710, 2, 32'hA5A5_0003, "abandon_flush_resp");

`ifdef OR1200_ICPU_RESP_LASTHIT_EN
    lv = '{32'h0000_0100, 4'hF, 4'h3, 3'd5, 0, 0, 1, 0, 32'h1500_0000, 0, 3, 1};
    run_vec(lv, "lh_fill");
    lv = '{32'h0000_0100, 4'hF, 4'h9, 3'd2, 0, 0, 1, 0, 32'h1500_0000, 0, 1, 0};
    run_vec(lv, "lh_hit");
    @(posedge clk); #1;
    bus.icpu_flush_i = 1'b1;
    @(posedge clk); #1;
    bus.icpu_flush_i = 1'b0;
    lv = '{32'h0000_0100, 4'hF, 4'h4, 3'd3, 0, 0, 1, 0, 32'h2A2A_2A2A, 0, 3, 1};
    run_vec(lv, "lh_after_flush");
`else
    lv = '{32'h0000_0100, 4'hF, 4'h9, 3'd2, 0, 0, 1, 0, 32'h2A2A_2A2A, 0, 3, 1};
    run_vec(lv, "refetch_mem");
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
